// File: rtl/cordic_sequencer.sv
// rtl/cordic_sequencer.sv - range-checks and quadrant-reduces an angle, drives a CORDIC core, corrects and holds its result
// Angles outside +/-pi are rejected; angles beyond +/-pi/2 are folded by pi and the core results negated.
module cordic_sequencer #(
  parameter int TIMEOUT = 32
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [18:0] in_angle,
  output logic [17:0] cordic_angle,
  output logic        cordic_init,
  input  logic [17:0] cordic_cos,
  input  logic [17:0] cordic_sin,
  input  logic        cordic_done,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [17:0] out_sine,
  output logic [17:0] out_cosine,
  output logic        out_err
);

  localparam logic [1:0] S_IDLE   = 2'd0;
  localparam logic [1:0] S_LAUNCH = 2'd1;
  localparam logic [1:0] S_WAIT   = 2'd2;
  localparam logic [1:0] S_HOLD   = 2'd3;

  localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(TIMEOUT - 1);

  localparam logic signed [18:0] PI_S      = 19'sd205887;
  localparam logic signed [18:0] HALF_PI_S = 19'sd102944;
  localparam logic [17:0]        PI_U      = 18'd205887;

  logic [1:0]    state_q, state_d;
  logic [17:0]   angle_q, angle_d;
  logic          flip_q, flip_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          err_q, err_d;
  logic [17:0]   sin_q, sin_d;
  logic [17:0]   cos_q, cos_d;

  logic          in_range;
  logic          red_flip;
  logic [17:0]   red_angle;

  // Reduction done modulo 2^18: the low bits of a +/- pi are exact after truncation.
  always_comb begin
    in_range  = ($signed(in_angle) <= PI_S) && ($signed(in_angle) >= -PI_S);
    red_flip  = 1'b0;
    red_angle = in_angle[17:0];
    if ($signed(in_angle) > HALF_PI_S) begin
      red_flip  = 1'b1;
      red_angle = in_angle[17:0] - PI_U;
    end else if ($signed(in_angle) < -HALF_PI_S) begin
      red_flip  = 1'b1;
      red_angle = in_angle[17:0] + PI_U;
    end
  end

  always_comb begin
    state_d = state_q;
    angle_d = angle_q;
    flip_d  = flip_q;
    cnt_d   = cnt_q;
    err_d   = err_q;
    sin_d   = sin_q;
    cos_d   = cos_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          if (in_range) begin
            angle_d = red_angle;
            flip_d  = red_flip;
            err_d   = 1'b0;
            state_d = S_LAUNCH;
          end else begin
            flip_d  = 1'b0;
            err_d   = 1'b1;
            sin_d   = '0;
            cos_d   = '0;
            state_d = S_HOLD;
          end
        end
      end
      S_LAUNCH: begin
        cnt_d   = '0;
        state_d = S_WAIT;
      end
      S_WAIT: begin
        // A done seen in the first WAIT cycle may belong to an earlier launch.
        if (cordic_done && (cnt_q != '0)) begin
          err_d   = 1'b0;
          sin_d   = flip_q ? (~cordic_sin + 18'd1) : cordic_sin;
          cos_d   = flip_q ? (~cordic_cos + 18'd1) : cordic_cos;
          state_d = S_HOLD;
        end else if (cnt_q == CNT_LAST) begin
          err_d   = 1'b1;
          sin_d   = '0;
          cos_d   = '0;
          state_d = S_HOLD;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      S_HOLD: begin
        if (out_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q <= S_IDLE;
      angle_q <= '0;
      flip_q  <= 1'b0;
      cnt_q   <= '0;
      err_q   <= 1'b0;
      sin_q   <= '0;
      cos_q   <= '0;
    end else begin
      state_q <= state_d;
      angle_q <= angle_d;
      flip_q  <= flip_d;
      cnt_q   <= cnt_d;
      err_q   <= err_d;
      sin_q   <= sin_d;
      cos_q   <= cos_d;
    end
  end

  assign in_ready     = (state_q == S_IDLE);
  assign cordic_init  = (state_q == S_LAUNCH);
  assign out_valid    = (state_q == S_HOLD);
  assign cordic_angle = angle_q;
  assign out_sine     = sin_q;
  assign out_cosine   = cos_q;
  assign out_err      = err_q;

endmodule

// File: tb/tb_cordic_sequencer.sv
// tb/tb_cordic_sequencer.sv - bench for cordic_sequencer
// Vector table, randomized transactions against a reference model, and handshake/reset corner sequences.
module tb_cordic_sequencer;

  localparam int TO = 32;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic [18:0] in_angle = '0;
  logic [17:0] cordic_sin = '0;
  logic [17:0] cordic_cos = '0;
  logic        cordic_done = 1'b0;
  logic        out_ready = 1'b0;
  logic        in_ready, cordic_init, out_valid, out_err;
  logic [17:0] cordic_angle, out_sine, out_cosine;

  cordic_sequencer #(.TIMEOUT(TO)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .in_angle(in_angle), .cordic_angle(cordic_angle), .cordic_init(cordic_init),
    .cordic_cos(cordic_cos), .cordic_sin(cordic_sin), .cordic_done(cordic_done),
    .out_valid(out_valid), .out_ready(out_ready), .out_sine(out_sine),
    .out_cosine(out_cosine), .out_err(out_err)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Core model: done pulses core_lat cycles after the init cycle; it ignores rst_n on purpose.
  logic        core_en = 1'b1;
  int          core_lat = 16;
  logic [17:0] core_s = '0;
  logic [17:0] core_c = '0;

  initial begin
    int cd;
    cd = 0;
    forever begin
      @(negedge clk);
      cordic_done = 1'b0;
      if (cd > 0) begin
        cd--;
        if (cd == 0) begin
          cordic_done = 1'b1;
          cordic_sin  = core_s;
          cordic_cos  = core_c;
        end
      end
      if (cordic_init && core_en) cd = core_lat;
    end
  end

  function automatic void ref_model(input logic [18:0] a, input logic [17:0] s, input logic [17:0] c,
                                    input int lat, output logic err, output logic [17:0] ang,
                                    output logic [17:0] so, output logic [17:0] co,
                                    output int n_init, output int latency);
    int v, r;
    bit flip;
    v = int'(a);
    if (a[18]) v -= 524288;
    ang = '0; so = '0; co = '0; err = 1'b1; n_init = 0; latency = 0;
    if (v <= 205887 && v >= -205887) begin
      flip = 1'b1;
      if (v > 102944)       r = v - 205887;
      else if (v < -102944) r = v + 205887;
      else begin r = v; flip = 1'b0; end
      ang = 18'(r);
      n_init = 1;
      if (lat < 2 || lat > TO) begin
        latency = TO + 1;
      end else begin
        err = 1'b0;
        latency = lat + 1;
        so = flip ? 18'(-int'(s)) : s;
        co = flip ? 18'(-int'(c)) : c;
      end
    end
  endfunction

  task automatic run_txn(input logic [18:0] a, input logic [17:0] s, input logic [17:0] c,
                         input int lat, input logic en,
                         output int n_init, output logic [17:0] ang, output logic err,
                         output logic [17:0] so, output logic [17:0] co, output int latency,
                         output logic stable, output logic ok);
    int init_i;
    core_s = s; core_c = c; core_lat = lat; core_en = en;
    @(negedge clk);
    in_angle = a;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    n_init = 0; init_i = -1; ok = 1'b0; stable = 1'b1; ang = '0; latency = 0;
    for (int i = 0; i < 200; i++) begin
      if (cordic_init) begin
        n_init++;
        init_i = i;
        ang = cordic_angle;
      end else if (n_init > 0 && cordic_angle !== ang) begin
        stable = 1'b0;
      end
      if (out_valid) begin
        ok = 1'b1;
        latency = i - init_i;
        break;
      end
      @(negedge clk);
    end
    err = out_err; so = out_sine; co = out_cosine;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
  endtask

  typedef struct {
    logic [18:0] a;
    logic [17:0] s;
    logic [17:0] c;
    logic        e_err;
    logic [17:0] e_ang;
    logic [17:0] e_sin;
    logic [17:0] e_cos;
  } vec_t;

  vec_t vecs[12];

  initial begin
    int n_init, latency, m_init, m_lat, lat, sel;
    logic [17:0] ang, so, co, m_ang, m_so, m_co, hs, hc;
    logic err, stable, ok, m_err, en, flag;
    logic [18:0] a;
    logic [17:0] rs, rc;

    vecs[0]  = '{19'h13333, 18'h0EE99, 18'h05CC1, 1'b0, 18'h13333, 18'h0EE99, 18'h05CC1};
    vecs[1]  = '{19'h28000, 18'h12345, 18'h04000, 1'b0, 18'h35BC1, 18'h2DCBB, 18'h3C000};
    vecs[2]  = '{19'h34000, 18'h11111, 18'h22222, 1'b1, 18'h00000, 18'h00000, 18'h00000};
    vecs[3]  = '{19'h19220, 18'h10000, 18'h00000, 1'b0, 18'h19220, 18'h10000, 18'h00000};
    vecs[4]  = '{19'h66DE0, 18'h30000, 18'h00000, 1'b0, 18'h26DE0, 18'h30000, 18'h00000};
    vecs[5]  = '{19'h3243F, 18'h00010, 18'h3FFF0, 1'b0, 18'h00000, 18'h3FFF0, 18'h00010};
    vecs[6]  = '{19'h4DBC1, 18'h00100, 18'h00200, 1'b0, 18'h00000, 18'h3FF00, 18'h3FE00};
    vecs[7]  = '{19'h32440, 18'h00100, 18'h00200, 1'b1, 18'h00000, 18'h00000, 18'h00000};
    vecs[8]  = '{19'h4DBC0, 18'h00100, 18'h00200, 1'b1, 18'h00000, 18'h00000, 18'h00000};
    vecs[9]  = '{19'h19221, 18'h08000, 18'h01000, 1'b0, 18'h26DE2, 18'h38000, 18'h3F000};
    vecs[10] = '{19'h66DDF, 18'h00001, 18'h3FFFF, 1'b0, 18'h1921E, 18'h3FFFF, 18'h00001};
    vecs[11] = '{19'h40000, 18'h00100, 18'h00200, 1'b1, 18'h00000, 18'h00000, 18'h00000};

    repeat (3) @(negedge clk);
    check("rst_init", cordic_init, 0);
    check("rst_angle", cordic_angle, 0);
    check("rst_valid", out_valid, 0);
    check("rst_err", out_err, 0);
    check("rst_sine", out_sine, 0);
    check("rst_cosine", out_cosine, 0);
    rst_n = 1'b1;
    @(negedge clk);
    check("rst_in_ready", in_ready, 1);

    for (int k = 0; k < 12; k++) begin
      run_txn(vecs[k].a, vecs[k].s, vecs[k].c, 16, 1'b1, n_init, ang, err, so, co, latency, stable, ok);
      check($sformatf("vec%0d_done", k), ok, 1);
      check($sformatf("vec%0d_err", k), err, vecs[k].e_err);
      check($sformatf("vec%0d_sine", k), so, vecs[k].e_sin);
      check($sformatf("vec%0d_cosine", k), co, vecs[k].e_cos);
      check($sformatf("vec%0d_inits", k), n_init, vecs[k].e_err ? 0 : 1);
      if (!vecs[k].e_err) begin
        check($sformatf("vec%0d_angle", k), ang, vecs[k].e_ang);
        check($sformatf("vec%0d_latency", k), latency, 17);
        check($sformatf("vec%0d_stable", k), stable, 1);
      end
    end

    // Done in the first WAIT cycle must be ignored, giving a timeout.
    run_txn(19'h01000, 18'h0ABCD, 18'h01234, 1, 1'b1, n_init, ang, err, so, co, latency, stable, ok);
    check("stale_done_err", err, 1);
    check("stale_done_sine", so, 0);
    check("stale_done_latency", latency, TO + 1);

    run_txn(19'h01000, 18'h0ABCD, 18'h01234, 16, 1'b0, n_init, ang, err, so, co, latency, stable, ok);
    check("timeout_err", err, 1);
    check("timeout_cosine", co, 0);
    check("timeout_latency", latency, TO + 1);

    // Earliest accepted done: second WAIT cycle.
    run_txn(19'h01000, 18'h0ABCD, 18'h01234, 2, 1'b1, n_init, ang, err, so, co, latency, stable, ok);
    check("early_done_err", err, 0);
    check("early_done_sine", so, 18'h0ABCD);
    check("early_done_latency", latency, 3);

    for (int k = 0; k < 40; k++) begin
      a  = 19'($urandom_range(0, 524287));
      rs = 18'($urandom);
      rc = 18'($urandom);
      sel = $urandom_range(0, 9);
      en  = (sel != 0);
      lat = (sel == 0) ? 0 : (sel == 1) ? 1 : $urandom_range(2, 20);
      run_txn(a, rs, rc, (lat == 0) ? 16 : lat, en, n_init, ang, err, so, co, latency, stable, ok);
      ref_model(a, rs, rc, lat, m_err, m_ang, m_so, m_co, m_init, m_lat);
      check($sformatf("rnd%0d_err a=%0h", k, a), err, m_err);
      check($sformatf("rnd%0d_sine a=%0h", k, a), so, m_so);
      check($sformatf("rnd%0d_cosine a=%0h", k, a), co, m_co);
      check($sformatf("rnd%0d_inits a=%0h", k, a), n_init, m_init);
      if (m_init != 0) begin
        check($sformatf("rnd%0d_angle a=%0h", k, a), ang, m_ang);
        check($sformatf("rnd%0d_latency a=%0h", k, a), latency, m_lat);
      end
    end

    // Back-pressure in HOLD: outputs frozen, new requests ignored.
    core_s = 18'h0EE99; core_c = 18'h05CC1; core_lat = 16; core_en = 1'b1;
    @(negedge clk);
    in_angle = 19'h13333;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    ok = 1'b0;
    for (int i = 0; i < 100; i++) begin
      if (out_valid) begin ok = 1'b1; break; end
      @(negedge clk);
    end
    check("hold_reached", ok, 1);
    hs = out_sine; hc = out_cosine;
    check("hold_sine", hs, 18'h0EE99);
    in_angle = 19'h28000;
    in_valid = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      if (!out_valid || in_ready || cordic_init || out_sine !== hs || out_cosine !== hc || out_err) flag = 1'b0;
    end
    check("hold_stable", flag, 1);
    in_valid = 1'b0;
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    check("hold_release_valid", out_valid, 0);
    check("hold_release_ready", in_ready, 1);
    @(negedge clk);
    check("hold_no_launch", cordic_init, 0);

    // Reset in the middle of WAIT; the core's late done must not produce a result.
    core_lat = 10;
    @(negedge clk);
    in_angle = 19'h13333;
    in_valid = 1'b1;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    flag = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (out_valid || !in_ready || cordic_init) flag = 1'b0;
    end
    check("midwait_rst_quiet", flag, 1);
    check("midwait_rst_angle", cordic_angle, 0);
    check("midwait_rst_err", out_err, 0);

    run_txn(19'h13333, 18'h0EE99, 18'h05CC1, 16, 1'b1, n_init, ang, err, so, co, latency, stable, ok);
    check("post_rst_sine", so, 18'h0EE99);
    check("post_rst_cosine", co, 18'h05CC1);
    check("post_rst_err", err, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
